rcn_slave_buf: RTL and testbench

Ring-side responder for the rcn bus: the target end of the transactions that bus masters launch. Watches the ring for requests whose address falls in its window, pulls them into a 4-entry buffer, presents them in order to a local device, and injects the completed responses back onto the ring. Sits between the ring and one memory-mapped peripheral or RAM. Total in-flight transactions are capped at 4.

---
 rtl/rcn_slave_buf.sv | 117 +++++++++++
 tb/tb_rcn_slave_buf.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rcn_slave_buf.sv
// rcn ring responder: takes in-window requests off the ring, serves them in order to a
// local device, and injects the completed responses back into free or consumed ring slots.
`timescale 1ns/1ps
module rcn_slave_buf #(
  parameter logic [21:0] ADDR_MASK = 22'h3F0000,
  parameter logic [21:0] ADDR_BASE = 22'h000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [66:0] rcn_in,
  output logic [66:0] rcn_out,
  output logic        cs,
  input  logic        busy,
  output logic        wr,
  output logic [3:0]  mask,
  output logic [21:0] addr,
  output logic [31:0] wdata,
  input  logic        done,
  input  logic [31:0] rdata
);

  logic        in_vld, in_pend, in_match;
  logic [21:0] in_byte_addr;
  logic [2:0]  inflight;
  logic        take, accept, cmpl, resp_pop;

  assign in_vld       = rcn_in[66];
  assign in_pend      = rcn_in[65];
  assign in_byte_addr = {rcn_in[53:34], 2'b00};
  assign in_match     = ((in_byte_addr & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));
  assign take         = in_vld & in_pend & in_match & (inflight != 3'd4);

  // Request FIFO: ring fields below valid/pending, {wr,id,mask,addr,seq,data}
  logic [64:0] req_mem [4];
  logic [1:0]  req_wp, req_rp;
  logic [2:0]  req_cnt;
  logic [64:0] req_head;

  assign req_head = req_mem[req_rp];
  assign cs       = (req_cnt != 3'd0);
  assign accept   = cs & ~busy;
  assign wr       = req_head[64];
  assign mask     = req_head[57:54];
  assign addr     = {req_head[53:34], 2'b00};
  assign wdata    = req_head[31:0];

  always_ff @(posedge CLK)
    if (take) req_mem[req_wp] <= rcn_in[64:0];

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      req_wp  <= '0;
      req_rp  <= '0;
      req_cnt <= '0;
    end else begin
      if (take)   req_wp <= req_wp + 2'd1;
      if (accept) req_rp <= req_rp + 2'd1;
      req_cnt <= req_cnt + {2'b00, take} - {2'b00, accept};
    end

  // Tag FIFO: accepted requests awaiting done, {wr,id,mask,addr,seq}
  logic [32:0] tag_mem [4];
  logic [1:0]  tag_wp, tag_rp;
  logic [2:0]  tag_cnt;
  logic [32:0] tag_head;

  assign tag_head = tag_mem[tag_rp];
  assign cmpl     = done & (tag_cnt != 3'd0);

  always_ff @(posedge CLK)
    if (accept) tag_mem[tag_wp] <= req_head[64:32];

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      tag_wp  <= '0;
      tag_rp  <= '0;
      tag_cnt <= '0;
    end else begin
      if (accept) tag_wp <= tag_wp + 2'd1;
      if (cmpl)   tag_rp <= tag_rp + 2'd1;
      tag_cnt <= tag_cnt + {2'b00, accept} - {2'b00, cmpl};
    end

  // Response FIFO: full ring words ready for injection
  logic [66:0] resp_mem [4];
  logic [1:0]  resp_wp, resp_rp;
  logic [2:0]  resp_cnt;
  logic [66:0] resp_word;

  // A response may only use an empty slot or the slot of a request being taken
  assign resp_pop  = (resp_cnt != 3'd0) & (~in_vld | take);
  assign resp_word = {1'b1, 1'b0, tag_head, tag_head[32] ? 32'd0 : rdata};

  always_ff @(posedge CLK)
    if (cmpl) resp_mem[resp_wp] <= resp_word;

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      resp_wp  <= '0;
      resp_rp  <= '0;
      resp_cnt <= '0;
      inflight <= '0;
    end else begin
      if (cmpl)     resp_wp <= resp_wp + 2'd1;
      if (resp_pop) resp_rp <= resp_rp + 2'd1;
      resp_cnt <= resp_cnt + {2'b00, cmpl} - {2'b00, resp_pop};
      inflight <= inflight + {2'b00, take} - {2'b00, resp_pop};
    end

  // Ring output stage
  always_ff @(posedge CLK or posedge RST)
    if (RST)           rcn_out <= '0;
    else if (resp_pop) rcn_out <= resp_mem[resp_rp];
    else if (take)     rcn_out <= '0;
    else               rcn_out <= rcn_in;

endmodule

// File: tb/tb_rcn_slave_buf.sv
// Directed bench for rcn_slave_buf: table of single-cycle vectors plus scripted
// sequences for buffer fill/retry, injection blocking and mid-traffic reset.
`timescale 1ns/1ps
module tb_rcn_slave_buf;

  logic        CLK = 1'b0;
  logic        RST;
  logic [66:0] rcn_in;
  logic [66:0] rcn_out;
  logic        cs, busy, wr, done;
  logic [3:0]  mask;
  logic [21:0] addr;
  logic [31:0] wdata, rdata;

  int tests = 0;
  int fails = 0;

  rcn_slave_buf dut (
    .CLK(CLK), .RST(RST), .rcn_in(rcn_in), .rcn_out(rcn_out), .cs(cs), .busy(busy),
    .wr(wr), .mask(mask), .addr(addr), .wdata(wdata), .done(done), .rdata(rdata)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [66:0] rin;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic [66:0] exp_out;
    logic        exp_cs;
    logic        chk_head;
    logic        exp_wr;
    logic [3:0]  exp_mask;
    logic [21:0] exp_addr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vq[$];

  function automatic logic [66:0] mk(input logic v, input logic p, input logic w,
                                     input logic [5:0] id, input logic [3:0] m,
                                     input logic [19:0] a, input logic [1:0] s,
                                     input logic [31:0] d);
    return {v, p, w, id, m, a, s, d};
  endfunction

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_head(input string name, input logic ew, input logic [3:0] em,
                            input logic [21:0] ea, input logic [31:0] ed);
    check({name, ".wr"},    67'(wr),    67'(ew));
    check({name, ".mask"},  67'(mask),  67'(em));
    check({name, ".addr"},  67'(addr),  67'(ea));
    check({name, ".wdata"}, 67'(wdata), 67'(ed));
  endtask

  task automatic step(input logic [66:0] rin, input logic b, input logic d,
                      input logic [31:0] rd);
    rcn_in = rin;
    busy   = b;
    done   = d;
    rdata  = rd;
    @(posedge CLK);
    #1;
  endtask

  task automatic add_vec(input logic [66:0] rin, input logic b, input logic d,
                         input logic [31:0] rd, input logic [66:0] eo, input logic ec,
                         input logic ch, input logic ew, input logic [3:0] em,
                         input logic [21:0] ea, input logic [31:0] ed);
    vec_t v;
    v.rin = rin; v.busy = b; v.done = d; v.rdata = rd;
    v.exp_out = eo; v.exp_cs = ec; v.chk_head = ch;
    v.exp_wr = ew; v.exp_mask = em; v.exp_addr = ea; v.exp_wdata = ed;
    vq.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [66:0] wreq, oreq, rsp_in, rreq, w2, w3;
    logic [66:0] q[5];
    logic [31:0] dd[5];
    logic [66:0] rsp[5];
    logic [66:0] inj_req, inj_rsp;

    RST = 1'b1; rcn_in = '0; busy = 1'b0; done = 1'b0; rdata = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset.rcn_out", rcn_out, 67'd0);
    check("reset.cs", 67'(cs), 67'd0);
    RST = 1'b0;
    step('0, 0, 0, 0);
    check("post_reset.rcn_out", rcn_out, 67'd0);

    // Table: single write, out-of-window pass, foreign response pass, single read
    wreq   = mk(1, 1, 1, 6'h05, 4'hF, 20'h0048D, 2'd2, 32'hDEADBEEF);
    oreq   = mk(1, 1, 0, 6'h03, 4'hF, 20'h10000, 2'd1, 32'h0);
    rsp_in = mk(1, 0, 0, 6'h07, 4'hF, 20'h00010, 2'd0, 32'h11112222);
    rreq   = mk(1, 1, 0, 6'h09, 4'h3, 20'h00020, 2'd1, 32'h0);
    add_vec(wreq, 1, 0, 0, 67'd0, 1, 1, 1, 4'hF, 22'h01234, 32'hDEADBEEF);
    add_vec('0, 0, 0, 0, 67'd0, 0, 0, 0, 0, 0, 0);
    add_vec('0, 0, 1, 32'hAAAA5555, 67'd0, 0, 0, 0, 0, 0, 0);
    add_vec('0, 0, 0, 0, mk(1, 0, 1, 6'h05, 4'hF, 20'h0048D, 2'd2, 32'h0), 0, 0, 0, 0, 0, 0);
    add_vec(oreq, 0, 0, 0, oreq, 0, 0, 0, 0, 0, 0);
    add_vec('0, 0, 0, 0, 67'd0, 0, 0, 0, 0, 0, 0);
    add_vec(rsp_in, 0, 0, 0, rsp_in, 0, 0, 0, 0, 0, 0);
    add_vec('0, 0, 0, 0, 67'd0, 0, 0, 0, 0, 0, 0);
    add_vec(rreq, 1, 0, 0, 67'd0, 1, 1, 0, 4'h3, 22'h00080, 32'h0);
    add_vec('0, 0, 0, 0, 67'd0, 0, 0, 0, 0, 0, 0);
    add_vec('0, 0, 1, 32'hCAFEF00D, 67'd0, 0, 0, 0, 0, 0, 0);
    add_vec('0, 0, 0, 0, mk(1, 0, 0, 6'h09, 4'h3, 20'h00020, 2'd1, 32'hCAFEF00D), 0, 0, 0, 0, 0, 0);

    foreach (vq[i]) begin
      step(vq[i].rin, vq[i].busy, vq[i].done, vq[i].rdata);
      check($sformatf("vec%0d.rcn_out", i), rcn_out, vq[i].exp_out);
      check($sformatf("vec%0d.cs", i), 67'(cs), 67'(vq[i].exp_cs));
      if (vq[i].chk_head)
        check_head($sformatf("vec%0d", i), vq[i].exp_wr, vq[i].exp_mask,
                   vq[i].exp_addr, vq[i].exp_wdata);
    end

    // Fill with busy high: four taken, fifth refused and passed on
    for (int i = 0; i < 5; i++) begin
      q[i]   = mk(1, 1, 0, 6'(10 + i), 4'hF, 20'(256 + i), 2'(i), 32'h0);
      dd[i]  = 32'hA000_0000 + 32'(i);
      rsp[i] = mk(1, 0, 0, 6'(10 + i), 4'hF, 20'(256 + i), 2'(i), dd[i]);
    end
    for (int i = 0; i < 5; i++) begin
      step(q[i], 1, 0, 0);
      check($sformatf("fill%0d.rcn_out", i), rcn_out, (i < 4) ? 67'd0 : q[i]);
    end
    check("fill.cs", 67'(cs), 67'd1);
    check_head("fill.head", 0, 4'hF, 22'h000400, 32'h0);

    step('0, 0, 0, 0);
    check("drain0.rcn_out", rcn_out, 67'd0);
    check("drain0.addr", 67'(addr), 67'(22'h000404));
    step('0, 0, 1, dd[0]);
    check("drain1.rcn_out", rcn_out, 67'd0);
    step('0, 0, 1, dd[1]);
    check("drain2.rcn_out", rcn_out, rsp[0]);
    // Retried fifth request arrives while a response is waiting: slot reused
    step(q[4], 0, 1, dd[2]);
    check("retry.rcn_out", rcn_out, rsp[1]);
    check("retry.cs", 67'(cs), 67'd1);
    check("retry.addr", 67'(addr), 67'(22'h000410));
    step('0, 0, 1, dd[3]);
    check("drain4.rcn_out", rcn_out, rsp[2]);
    check("drain4.cs", 67'(cs), 67'd0);
    step('0, 0, 1, dd[4]);
    check("drain5.rcn_out", rcn_out, rsp[3]);
    step('0, 0, 0, 0);
    check("drain6.rcn_out", rcn_out, rsp[4]);
    step('0, 0, 0, 0);
    check("drain7.rcn_out", rcn_out, 67'd0);

    // Injection held off by unmatched valid traffic
    inj_req = mk(1, 1, 0, 6'h21, 4'hF, 20'h00300, 2'd3, 32'h0);
    inj_rsp = mk(1, 0, 0, 6'h21, 4'hF, 20'h00300, 2'd3, 32'h12345678);
    step(inj_req, 0, 0, 0);
    check("inj.take", rcn_out, 67'd0);
    step('0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      logic [66:0] u;
      u = mk(1, 1, 0, 6'(48 + k), 4'hF, 20'(32'h10000 + k), 2'd0, 32'(k));
      step(u, 0, (k == 0), (k == 0) ? 32'h12345678 : 32'h0);
      check($sformatf("inj.block%0d", k), rcn_out, u);
    end
    step('0, 0, 0, 0);
    check("inj.emit", rcn_out, inj_rsp);
    step('0, 0, 0, 0);
    check("inj.after", rcn_out, 67'd0);

    // Reset with traffic active
    w2 = mk(1, 1, 1, 6'h02, 4'hF, 20'h00004, 2'd0, 32'h1);
    w3 = mk(1, 1, 1, 6'h03, 4'hF, 20'h00008, 2'd1, 32'h2);
    step(w2, 1, 0, 0);
    step(w3, 0, 0, 0);
    step(oreq, 1, 0, 0);
    check("prerst.rcn_out", rcn_out, oreq);
    check("prerst.cs", 67'(cs), 67'd1);
    RST = 1'b1;
    rcn_in = '0;
    #1;
    check("midrst.rcn_out", rcn_out, 67'd0);
    check("midrst.cs", 67'(cs), 67'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    step('0, 0, 1, 32'h55AA55AA);
    check("flush.done_ignored", rcn_out, 67'd0);
    step('0, 0, 0, 0);
    check("flush.no_resp", rcn_out, 67'd0);
    check("flush.cs", 67'(cs), 67'd0);
    for (int i = 0; i < 4; i++) begin
      step(mk(1, 1, 0, 6'(56 + i), 4'hF, 20'(32'h200 + i), 2'd0, 32'h0), 1, 0, 0);
      check($sformatf("refill%0d.rcn_out", i), rcn_out, 67'd0);
    end

    done = 1'b0;
    rcn_in = '0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
